// File: rtl/ucode_pkg.sv
// Shared types and constants for the microcode sequencer: FSM states,
// sequencing codes, control-word layout and the safe idle word.
package ucode_pkg;

  localparam int CW_W   = 41;
  localparam int SEQ_W  = 2;
  localparam int WORD_W = SEQ_W + CW_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [SEQ_W-1:0] {
    SEQ_ADV  = 2'b00,  // pc + 1
    SEQ_LAST = 2'b01,  // halt after this word
    SEQ_SKZ  = 2'b10,  // pc + 2 when Z is set
    SEQ_SKNZ = 2'b11   // pc + 2 when Z is clear
  } seq_e;

  // One control-store entry: sequencing field above the datapath word.
  typedef struct packed {
    seq_e            seq;
    logic [CW_W-1:0] cw;
  } ucode_word_t;

  // Control-word field LSB positions and widths, MSB-first order
  // RF_OutASel ... MuxCSel.
  localparam int RF_OUTASEL_LSB  = 38;  localparam int RF_OUTASEL_W  = 3;
  localparam int RF_OUTBSEL_LSB  = 35;  localparam int RF_OUTBSEL_W  = 3;
  localparam int RF_FUNSEL_LSB   = 33;  localparam int RF_FUNSEL_W   = 2;
  localparam int RF_RSEL_LSB     = 29;  localparam int RF_RSEL_W     = 4;
  localparam int RF_TSEL_LSB     = 25;  localparam int RF_TSEL_W     = 4;
  localparam int ALU_FUNSEL_LSB  = 21;  localparam int ALU_FUNSEL_W  = 4;
  localparam int ARF_OUTCSEL_LSB = 19;  localparam int ARF_OUTCSEL_W = 2;
  localparam int ARF_OUTDSEL_LSB = 17;  localparam int ARF_OUTDSEL_W = 2;
  localparam int ARF_FUNSEL_LSB  = 15;  localparam int ARF_FUNSEL_W  = 2;
  localparam int ARF_REGSEL_LSB  = 11;  localparam int ARF_REGSEL_W  = 4;
  localparam int IR_LH_BIT       = 10;
  localparam int IR_ENABLE_BIT   = 9;
  localparam int IR_FUNSEL_LSB   = 7;   localparam int IR_FUNSEL_W   = 2;
  localparam int MEM_WR_BIT      = 6;
  localparam int MEM_CS_BIT      = 5;
  localparam int MUXASEL_LSB     = 3;   localparam int MUXASEL_W     = 2;
  localparam int MUXBSEL_LSB     = 1;   localparam int MUXBSEL_W     = 2;
  localparam int MUXCSEL_BIT     = 0;

  // Safe no-op word driven whenever no stored word is being issued.
  localparam logic [CW_W-1:0] IDLE_CW_DEFAULT = 41'h00000000006;

endpackage

// File: rtl/ucode_store.sv
// Writable control store: DEPTH entries of {seq, control word}, written
// on the clock edge and read combinationally.
module ucode_store
  import ucode_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        Clock,
  input  logic        wr_en,
  input  logic [AW-1:0] wr_addr,
  input  ucode_word_t wr_data,
  input  logic [AW-1:0] rd_addr,
  output ucode_word_t rd_data
);

  ucode_word_t mem_q [DEPTH];

  // Program one entry per write strobe.
  // NOTE: the array has no reset; program contents must survive Reset,
  // and leaving it out keeps the array mappable to plain storage.
  always_ff @(posedge Clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/microcode_sequencer.sv
// Stored-program control-word sequencer: after start, issues one control
// word per clock from the control store, with conditional skips on the
// ALU Z flag, stall bubbles, and overrun detection at the store end.
module microcode_sequencer
  import ucode_pkg::*;
#(
  parameter int              DEPTH   = 16,
  parameter int              AW      = 4,
  parameter logic [CW_W-1:0] IDLE_CW = IDLE_CW_DEFAULT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [WORD_W-1:0] prog_data,
  input  logic              start,
  input  logic [AW-1:0]     start_addr,
  input  logic              stall,
  input  logic [3:0]        alu_flags,
  output logic [CW_W-1:0]   control_word,
  output logic [AW-1:0]     pc,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [CW_W-1:0] cw_q, cw_d;
  seq_e            seq_q, seq_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            store_we;
  logic [AW-1:0]   rd_addr;
  ucode_word_t     rd_word;
  logic            flag_z;
  logic [AW:0]     step;
  logic [AW:0]     next_pc;
  logic            unused_flags;

  // Only Z steers sequencing; the other flags are accepted for bus symmetry.
  assign flag_z       = alu_flags[3];
  assign unused_flags = ^alu_flags[2:0];

  // The store may only be reprogrammed while no program is executing.
  assign store_we = prog_we && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  ucode_store #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .Clock   (Clock),
    .wr_en   (store_we),
    .wr_addr (prog_addr),
    .wr_data (ucode_word_t'(prog_data)),
    .rd_addr (rd_addr),
    .rd_data (rd_word)
  );

  // Next-pc, store read address and FSM next-state/output selection.
  // NOTE: every variable gets a default at the top so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cw_d    = cw_q;
    seq_d   = seq_q;
    error_d = error_q;
    done_d  = 1'b0;

    // One extra bit so that stepping past DEPTH-1 is visible, not wrapped.
    unique case (seq_q)
      SEQ_SKZ:  step = flag_z ? (AW+1)'(2) : (AW+1)'(1);
      SEQ_SKNZ: step = flag_z ? (AW+1)'(1) : (AW+1)'(2);
      default:  step = (AW+1)'(1);
    endcase
    next_pc = {1'b0, pc_q} + step;

    unique case (state_q)
      ST_RUN:   rd_addr = next_pc[AW-1:0];
      ST_STALL: rd_addr = pc_q;
      default:  rd_addr = start_addr;
    endcase

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = start_addr;
          cw_d    = rd_word.cw;
          seq_d   = rd_word.seq;
          error_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stall) begin
          // Current word is withdrawn and re-issued once the stall clears.
          cw_d    = IDLE_CW;
          state_d = ST_STALL;
        end else if (seq_q == SEQ_LAST) begin
          cw_d    = IDLE_CW;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (next_pc[AW]) begin
          cw_d    = IDLE_CW;
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          pc_d  = next_pc[AW-1:0];
          cw_d  = rd_word.cw;
          seq_d = rd_word.seq;
        end
      end
      ST_STALL: begin
        if (!stall) begin
          cw_d    = rd_word.cw;
          seq_d   = rd_word.seq;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_STALL);
  end

  // State and registered outputs, with synchronous active-low reset.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cw_q    <= IDLE_CW;
      seq_q   <= SEQ_ADV;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cw_q    <= cw_d;
      seq_q   <= seq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign control_word = cw_q;
  assign pc           = pc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule
